// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings: branch kinds and the branch-resolve FSM states.
package mips_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BGEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLEZ = 3'd5,
        BR_BLTZ = 3'd6,
        BR_RSVD = 3'd7
    } br_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_REDIRECT = 2'd2
    } br_state_e;

    // A real branch is anything other than the "no branch" encoding.
    function automatic logic is_branch(input br_type_e t);
        return t != BR_NONE;
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// ID-stage branch request/response bundle between the decode pipeline
// (master) and the branch resolver (slave).
interface branch_resolve_if #(
    parameter int DW = 32
) ();
    logic          br_valid;
    logic [2:0]    br_type;
    logic          cmp_eq;
    logic          cmp_gez;
    logic          cmp_gtz;
    logic          cmp_lez;
    logic          cmp_ltz;
    logic          opnd_wait;
    logic [DW-1:0] pc_plus4;
    logic [DW-1:0] imm_ext;
    logic          br_ack;
    logic          stall_id;
    logic          pc_redirect;
    logic [DW-1:0] br_target;
    logic          flush_if;

    modport master (
        output br_valid, br_type, cmp_eq, cmp_gez, cmp_gtz, cmp_lez, cmp_ltz,
               opnd_wait, pc_plus4, imm_ext,
        input  br_ack, stall_id, pc_redirect, br_target, flush_if
    );

    modport slave (
        input  br_valid, br_type, cmp_eq, cmp_gez, cmp_gtz, cmp_lez, cmp_ltz,
               opnd_wait, pc_plus4, imm_ext,
        output br_ack, stall_id, pc_redirect, br_target, flush_if
    );
endinterface

// File: rtl/branch_resolve_br_cond.sv
// Branch condition evaluation: branch kind + comparator flags -> taken.
module br_cond
    import mips_pkg::*;
(
    input  br_type_e br_type,
    input  logic     cmp_eq,
    input  logic     cmp_gez,
    input  logic     cmp_gtz,
    input  logic     cmp_lez,
    input  logic     cmp_ltz,
    output logic     taken
);

    // Select the flag matching the branch kind; NONE and reserved never take.
    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_BEQ:  taken = cmp_eq;
            BR_BNE:  taken = !cmp_eq;
            BR_BGEZ: taken = cmp_gez;
            BR_BGTZ: taken = cmp_gtz;
            BR_BLEZ: taken = cmp_lez;
            BR_BLTZ: taken = cmp_ltz;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch resolver: stalls on operand hazards, acks resolved
// branches, and redirects/flushes fetch for one cycle on a taken branch.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolve
    import mips_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolve_if.slave  bif,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    br_state_e     state;
    br_type_e      btype;
    logic          is_br;
    logic          taken;
    logic          resolve;
    logic          enter_hold;
    logic          stall;
    logic          redirect_q;
    logic [DW-1:0] target_q;

    assign btype = br_type_e'(bif.br_type);
    assign is_br = is_branch(btype);

    br_cond u_cond (
        .br_type (btype),
        .cmp_eq  (bif.cmp_eq),
        .cmp_gez (bif.cmp_gez),
        .cmp_gtz (bif.cmp_gtz),
        .cmp_lez (bif.cmp_lez),
        .cmp_ltz (bif.cmp_ltz),
        .taken   (taken)
    );

    // Same-cycle resolve/stall decision; gated by rst_n so outputs drop during reset.
    always_comb begin
        resolve    = 1'b0;
        enter_hold = 1'b0;
        stall      = 1'b0;
        if (rst_n && bif.br_valid) begin
            case (state)
                ST_IDLE: begin
                    if (!is_br || !bif.opnd_wait) begin
                        resolve = 1'b1;
                    end else begin
                        enter_hold = 1'b1;
                        stall      = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!bif.opnd_wait) resolve = 1'b1;
                    else                stall   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // FSM with registered redirect strobe and branch target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            redirect_q <= 1'b0;
            target_q   <= '0;
        end else begin
            redirect_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enter_hold) begin
                        state <= ST_HOLD;
                    end else if (resolve && taken) begin
                        state      <= ST_REDIRECT;
                        redirect_q <= 1'b1;
                        target_q   <= bif.pc_plus4 + (bif.imm_ext << 2);
                    end
                end
                ST_HOLD: begin
                    if (!bif.br_valid) begin
                        state <= ST_IDLE;
                    end else if (resolve) begin
                        if (taken) begin
                            state      <= ST_REDIRECT;
                            redirect_q <= 1'b1;
                            target_q   <= bif.pc_plus4 + (bif.imm_ext << 2);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bif.br_ack      = resolve;
    assign bif.stall_id    = stall;
    assign bif.pc_redirect = redirect_q;
    assign bif.flush_if    = redirect_q;
    assign bif.br_target   = target_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_q;
    logic [CNT_W-1:0] tk_q;

    // Saturating counts of resolved and taken real branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_q <= '0;
            tk_q <= '0;
        end else if (resolve && is_br) begin
            if (br_q != '1)           br_q <= br_q + CNT_W'(1);
            if (taken && tk_q != '1)  tk_q <= tk_q + CNT_W'(1);
        end
    end

    assign br_cnt    = br_q;
    assign taken_cnt = tk_q;
`else
    assign br_cnt    = '0;
    assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (CNT_W=4 to reach saturation).
module tb_branch_resolve;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] br_cnt;
    logic [3:0] taken_cnt;
    int         checks   = 0;
    int         failures = 0;
    int         exp_br   = 0;
    int         exp_tk   = 0;

    branch_resolve_if #(.DW(32)) bif ();

    branch_resolve #(.DW(32), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bif       (bif),
        .br_cnt    (br_cnt),
        .taken_cnt (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [2:0] t, input logic [4:0] f,
                         input logic w, input logic [31:0] pc, input logic [31:0] imm);
        bif.br_valid  = v;
        bif.br_type   = t;
        {bif.cmp_eq, bif.cmp_gez, bif.cmp_gtz, bif.cmp_lez, bif.cmp_ltz} = f;
        bif.opnd_wait = w;
        bif.pc_plus4  = pc;
        bif.imm_ext   = imm;
    endtask

    task automatic idle_in();
        drive(1'b0, 3'd0, 5'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Expected-counter model: only advances when statistics are built in.
    function automatic void bump(input logic tk);
`ifdef BRANCH_STATS_EN
        if (exp_br < 15) exp_br++;
        if (tk && exp_tk < 15) exp_tk++;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 3'd1, 5'b10000, 1'b0, 32'h10, 32'h1);
        #1;
        checks++; if (bif.br_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b want=0", bif.br_ack); end
        checks++; if (bif.stall_id !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b want=0", bif.stall_id); end
        checks++; if (bif.pc_redirect !== 1'b0) begin failures++; $display("FAIL rst_redirect got=%b want=0", bif.pc_redirect); end
        checks++; if (bif.flush_if !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b want=0", bif.flush_if); end
        checks++; if (bif.br_target !== 32'h0) begin failures++; $display("FAIL rst_target got=%h want=0", bif.br_target); end
        checks++; if (br_cnt !== 4'h0 || taken_cnt !== 4'h0) begin failures++; $display("FAIL rst_cnt got=%h/%h want=0/0", br_cnt, taken_cnt); end
        @(negedge clk);
        idle_in();
        rst_n = 1'b1;
    endtask

    task automatic test_beq_taken();
        @(negedge clk);
        drive(1'b1, 3'd1, 5'b10000, 1'b0, 32'h00400004, 32'h00000003);
        #1;
        checks++; if (bif.br_ack !== 1'b1) begin failures++; $display("FAIL beq_ack got=%b want=1", bif.br_ack); end
        checks++; if (bif.stall_id !== 1'b0) begin failures++; $display("FAIL beq_stall got=%b want=0", bif.stall_id); end
        checks++; if (bif.pc_redirect !== 1'b0) begin failures++; $display("FAIL beq_early_redirect got=%b want=0", bif.pc_redirect); end
        bump(1'b1);
        @(negedge clk);
        idle_in();
        #1;
        checks++; if (bif.pc_redirect !== 1'b1 || bif.flush_if !== 1'b1) begin failures++; $display("FAIL beq_redirect got=%b/%b want=1/1", bif.pc_redirect, bif.flush_if); end
        checks++; if (bif.br_target !== 32'h00400010) begin failures++; $display("FAIL beq_target got=%h want=00400010", bif.br_target); end
        checks++; if (bif.stall_id !== 1'b0 || bif.br_ack !== 1'b0) begin failures++; $display("FAIL beq_redir_stall_ack got=%b/%b want=0/0", bif.stall_id, bif.br_ack); end
        checks++; if (br_cnt !== 4'(exp_br) || taken_cnt !== 4'(exp_tk)) begin failures++; $display("FAIL beq_cnt got=%h/%h want=%h/%h", br_cnt, taken_cnt, exp_br, exp_tk); end
        @(negedge clk);
        #1;
        checks++; if (bif.pc_redirect !== 1'b0 || bif.flush_if !== 1'b0) begin failures++; $display("FAIL beq_redirect_len got=%b/%b want=0/0", bif.pc_redirect, bif.flush_if); end
        checks++; if (bif.br_target !== 32'h00400010) begin failures++; $display("FAIL beq_target_hold got=%h want=00400010", bif.br_target); end
    endtask

    task automatic test_bne_not_taken();
        @(negedge clk);
        drive(1'b1, 3'd2, 5'b10000, 1'b0, 32'h2000, 32'h5);
        #1;
        checks++; if (bif.br_ack !== 1'b1) begin failures++; $display("FAIL bne_ack got=%b want=1", bif.br_ack); end
        bump(1'b0);
        @(negedge clk);
        idle_in();
        #1;
        checks++; if (bif.pc_redirect !== 1'b0) begin failures++; $display("FAIL bne_redirect got=%b want=0", bif.pc_redirect); end
        checks++; if (bif.br_target !== 32'h00400010) begin failures++; $display("FAIL bne_target_hold got=%h want=00400010", bif.br_target); end
        checks++; if (br_cnt !== 4'(exp_br) || taken_cnt !== 4'(exp_tk)) begin failures++; $display("FAIL bne_cnt got=%h/%h want=%h/%h", br_cnt, taken_cnt, exp_br, exp_tk); end
    endtask

    task automatic test_hold_bltz();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 3'd6, 5'b00000, 1'b1, 32'h1000, 32'hFFFFFFFE);
            #1;
            checks++; if (bif.stall_id !== 1'b1 || bif.br_ack !== 1'b0) begin failures++; $display("FAIL hold_stall[%0d] got=%b/%b want=1/0", i, bif.stall_id, bif.br_ack); end
        end
        @(negedge clk);
        drive(1'b1, 3'd6, 5'b00001, 1'b0, 32'h1000, 32'hFFFFFFFE);
        #1;
        checks++; if (bif.br_ack !== 1'b1 || bif.stall_id !== 1'b0) begin failures++; $display("FAIL hold_resolve got=%b/%b want=1/0", bif.br_ack, bif.stall_id); end
        checks++; if (bif.pc_redirect !== 1'b0) begin failures++; $display("FAIL hold_early_redirect got=%b want=0", bif.pc_redirect); end
        bump(1'b1);
        @(negedge clk);
        idle_in();
        #1;
        checks++; if (bif.pc_redirect !== 1'b1 || bif.br_target !== 32'h00000FF8) begin failures++; $display("FAIL hold_redirect got=%b/%h want=1/00000ff8", bif.pc_redirect, bif.br_target); end
        checks++; if (br_cnt !== 4'(exp_br) || taken_cnt !== 4'(exp_tk)) begin failures++; $display("FAIL hold_cnt got=%h/%h want=%h/%h", br_cnt, taken_cnt, exp_br, exp_tk); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        drive(1'b1, 3'd3, 5'b01000, 1'b0, 32'h00000000, 32'hFFFFFFFF);
        #1;
        checks++; if (bif.br_ack !== 1'b1) begin failures++; $display("FAIL wrap_ack got=%b want=1", bif.br_ack); end
        bump(1'b1);
        @(negedge clk);
        idle_in();
        #1;
        checks++; if (bif.pc_redirect !== 1'b1 || bif.br_target !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_target got=%b/%h want=1/fffffffc", bif.pc_redirect, bif.br_target); end
    endtask

    task automatic test_none();
        @(negedge clk);
        drive(1'b1, 3'd0, 5'b11111, 1'b1, 32'h40, 32'h1);
        #1;
        checks++; if (bif.br_ack !== 1'b1 || bif.stall_id !== 1'b0) begin failures++; $display("FAIL none_ack got=%b/%b want=1/0", bif.br_ack, bif.stall_id); end
        @(negedge clk);
        idle_in();
        #1;
        checks++; if (bif.pc_redirect !== 1'b0) begin failures++; $display("FAIL none_redirect got=%b want=0", bif.pc_redirect); end
        checks++; if (br_cnt !== 4'(exp_br) || taken_cnt !== 4'(exp_tk)) begin failures++; $display("FAIL none_cnt got=%h/%h want=%h/%h", br_cnt, taken_cnt, exp_br, exp_tk); end
    endtask

    task automatic test_drop_in_hold();
        @(negedge clk);
        drive(1'b1, 3'd1, 5'b10000, 1'b1, 32'h80, 32'h2);
        #1;
        checks++; if (bif.stall_id !== 1'b1 || bif.br_ack !== 1'b0) begin failures++; $display("FAIL drop_stall got=%b/%b want=1/0", bif.stall_id, bif.br_ack); end
        @(negedge clk);
        drive(1'b1, 3'd1, 5'b10000, 1'b1, 32'h80, 32'h2);
        #1;
        checks++; if (bif.stall_id !== 1'b1) begin failures++; $display("FAIL drop_hold_stall got=%b want=1", bif.stall_id); end
        @(negedge clk);
        idle_in();
        #1;
        checks++; if (bif.br_ack !== 1'b0 || bif.stall_id !== 1'b0) begin failures++; $display("FAIL drop_release got=%b/%b want=0/0", bif.br_ack, bif.stall_id); end
        @(negedge clk);
        #1;
        checks++; if (bif.pc_redirect !== 1'b0) begin failures++; $display("FAIL drop_redirect got=%b want=0", bif.pc_redirect); end
        checks++; if (br_cnt !== 4'(exp_br) || taken_cnt !== 4'(exp_tk)) begin failures++; $display("FAIL drop_cnt got=%h/%h want=%h/%h", br_cnt, taken_cnt, exp_br, exp_tk); end
        // A fresh branch after the drop must be accepted straight from IDLE.
        @(negedge clk);
        drive(1'b1, 3'd1, 5'b10000, 1'b0, 32'h80, 32'h2);
        #1;
        checks++; if (bif.br_ack !== 1'b1) begin failures++; $display("FAIL drop_reaccept got=%b want=1", bif.br_ack); end
        bump(1'b1);
        @(negedge clk);
        idle_in();
        #1;
        checks++; if (bif.pc_redirect !== 1'b1 || bif.br_target !== 32'h00000088) begin failures++; $display("FAIL drop_reaccept_target got=%b/%h want=1/00000088", bif.pc_redirect, bif.br_target); end
    endtask

    task automatic test_conds();
        logic [2:0] ty [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd3};
        logic [4:0] fl [9] = '{5'b00000, 5'b01111, 5'b10111, 5'b00100, 5'b00010,
                               5'b11101, 5'b11110, 5'b11111, 5'b01000};
        logic       tk [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(1'b1, ty[i], fl[i], 1'b0, 32'h100, 32'h1);
            #1;
            checks++; if (bif.br_ack !== 1'b1) begin failures++; $display("FAIL cond_ack[%0d] got=%b want=1", i, bif.br_ack); end
            bump(tk[i]);
            @(negedge clk);
            idle_in();
            #1;
            checks++; if (bif.pc_redirect !== tk[i]) begin failures++; $display("FAIL cond_taken[%0d] type=%0d got=%b want=%b", i, ty[i], bif.pc_redirect, tk[i]); end
            if (tk[i]) begin
                checks++; if (bif.br_target !== 32'h00000104) begin failures++; $display("FAIL cond_target[%0d] got=%h want=00000104", i, bif.br_target); end
            end
        end
        checks++; if (br_cnt !== 4'(exp_br) || taken_cnt !== 4'(exp_tk)) begin failures++; $display("FAIL cond_cnt got=%h/%h want=%h/%h", br_cnt, taken_cnt, exp_br, exp_tk); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b1, 3'd1, 5'b10000, 1'b0, 32'h3000, 32'h4);
        #1;
        checks++; if (bif.br_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack1 got=%b want=1", bif.br_ack); end
        bump(1'b1);
        @(negedge clk);
        drive(1'b1, 3'd2, 5'b00000, 1'b0, 32'h4000, 32'h10);
        #1;
        checks++; if (bif.br_ack !== 1'b0 || bif.stall_id !== 1'b0) begin failures++; $display("FAIL b2b_redirect_accept got=%b/%b want=0/0", bif.br_ack, bif.stall_id); end
        checks++; if (bif.pc_redirect !== 1'b1 || bif.br_target !== 32'h00003010) begin failures++; $display("FAIL b2b_redirect1 got=%b/%h want=1/00003010", bif.pc_redirect, bif.br_target); end
        @(negedge clk);
        #1;
        checks++; if (bif.br_ack !== 1'b1 || bif.pc_redirect !== 1'b0) begin failures++; $display("FAIL b2b_ack2 got=%b/%b want=1/0", bif.br_ack, bif.pc_redirect); end
        bump(1'b1);
        @(negedge clk);
        idle_in();
        #1;
        checks++; if (bif.pc_redirect !== 1'b1 || bif.br_target !== 32'h00004040) begin failures++; $display("FAIL b2b_redirect2 got=%b/%h want=1/00004040", bif.pc_redirect, bif.br_target); end
        checks++; if (br_cnt !== 4'(exp_br) || taken_cnt !== 4'(exp_tk)) begin failures++; $display("FAIL b2b_cnt got=%h/%h want=%h/%h", br_cnt, taken_cnt, exp_br, exp_tk); end
    endtask

    task automatic test_reset_redirect();
        @(negedge clk);
        drive(1'b1, 3'd1, 5'b10000, 1'b0, 32'h5000, 32'h1);
        #1;
        bump(1'b1);
        @(negedge clk);
        drive(1'b1, 3'd1, 5'b10000, 1'b0, 32'h6000, 32'h1);
        #1;
        checks++; if (bif.pc_redirect !== 1'b1) begin failures++; $display("FAIL rr_in_redirect got=%b want=1", bif.pc_redirect); end
        rst_n = 1'b0;
        #1;
        checks++; if (bif.pc_redirect !== 1'b0 || bif.flush_if !== 1'b0) begin failures++; $display("FAIL rr_redirect got=%b/%b want=0/0", bif.pc_redirect, bif.flush_if); end
        checks++; if (bif.br_ack !== 1'b0 || bif.stall_id !== 1'b0) begin failures++; $display("FAIL rr_ack_stall got=%b/%b want=0/0", bif.br_ack, bif.stall_id); end
        checks++; if (bif.br_target !== 32'h0) begin failures++; $display("FAIL rr_target got=%h want=0", bif.br_target); end
        checks++; if (br_cnt !== 4'h0 || taken_cnt !== 4'h0) begin failures++; $display("FAIL rr_cnt got=%h/%h want=0/0", br_cnt, taken_cnt); end
        exp_br = 0;
        exp_tk = 0;
        @(negedge clk);
        idle_in();
        rst_n = 1'b1;
        #1;
        checks++; if (bif.pc_redirect !== 1'b0) begin failures++; $display("FAIL rr_release got=%b want=0", bif.pc_redirect); end
        @(negedge clk);
        #1;
        checks++; if (bif.pc_redirect !== 1'b0 || bif.flush_if !== 1'b0) begin failures++; $display("FAIL rr_after got=%b/%b want=0/0", bif.pc_redirect, bif.flush_if); end
    endtask

    task automatic test_saturate();
        logic [3:0] want;
`ifdef BRANCH_STATS_EN
        want = 4'hF;
`else
        want = 4'h0;
`endif
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(1'b1, 3'd1, 5'b10000, 1'b0, 32'(i * 4), 32'h0);
            #1;
            bump(1'b1);
            @(negedge clk);
            idle_in();
        end
        @(negedge clk);
        #1;
        checks++; if (br_cnt !== want || taken_cnt !== want) begin failures++; $display("FAIL sat_cnt got=%h/%h want=%h/%h", br_cnt, taken_cnt, want, want); end
        checks++; if (br_cnt !== 4'(exp_br)) begin failures++; $display("FAIL sat_model got=%h want=%h", br_cnt, exp_br); end
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_bne_not_taken();
        test_hold_bltz();
        test_wrap();
        test_none();
        test_drop_in_hold();
        test_conds();
        test_back_to_back();
        test_reset_redirect();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter DW, default 32, width of pc_plus4, imm_ext and br_target.
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port br_valid, input, 1, ID-stage branch present; held high until br_ack.
REQ-006 SHALL have port br_type, input, 3, branch kind: 0 NONE, 1 BEQ, 2 BNE, 3 BGEZ, 4 BGTZ, 5 BLEZ, 6 BLTZ, 7 reserved.
REQ-007 SHALL have port cmp_eq, cmp_gez, cmp_gtz, cmp_lez, cmp_ltz, input, 1 each, compare flags from the equality/sign comparator.
REQ-008 SHALL have port opnd_wait, input, 1, branch operands not yet forwarded (hazard pending).
REQ-009 SHALL have port pc_plus4, input, DW, PC+4 of the branch.
REQ-010 SHALL have port imm_ext, input, DW, sign-extended 16-bit offset.
REQ-011 SHALL have port br_ack, output, 1, one-cycle pulse when a branch is resolved.
REQ-012 SHALL have port stall_id, output, 1, hold the IF/ID stages.
REQ-013 SHALL have port pc_redirect, output, 1, select br_target as the next PC.
REQ-014 SHALL have port br_target, output, DW, registered target.
REQ-015 SHALL have port flush_if, output, 1, squash the IF/ID register.
REQ-016 SHALL have port br_cnt, output, CNT_W, branches resolved.
REQ-017 SHALL have port taken_cnt, output, CNT_W, branches taken.

Function
REQ-018 SHALL implement an FSM with states IDLE, HOLD and REDIRECT.
REQ-019 IDLE, br_valid=1, br_type!=0, opnd_wait=1 SHALL go to HOLD; stall_id=1 combinationally in that cycle.
REQ-020 HOLD SHALL keep stall_id=1 while opnd_wait=1, and SHALL resolve in the first cycle opnd_wait=0.
REQ-021 Resolve (in IDLE or HOLD with opnd_wait=0) SHALL pulse br_ack and evaluate taken from the flags: BEQ=eq, BNE=!eq, BGEZ=gez, BGTZ=gtz, BLEZ=lez, BLTZ=ltz; types 0 and 7 are not taken.
REQ-022 Taken SHALL register br_target = pc_plus4 + (imm_ext<<2), modulo 2^DW, and go to REDIRECT; not taken SHALL return to IDLE.
REQ-023 REDIRECT SHALL last exactly one cycle with pc_redirect=1, flush_if=1 and stall_id=0, then go to IDLE (latency resolve to redirect = 1 cycle).
REQ-024 br_valid arriving in REDIRECT SHALL NOT be accepted; it is accepted in the following IDLE cycle.
REQ-025 br_valid with br_type=0 SHALL be acked immediately without stall, redirect or counting.
REQ-026 br_valid dropping in HOLD SHALL return the FSM to IDLE with no ack and no count.
REQ-027 br_target SHALL hold its last value outside REDIRECT.

Reset
REQ-028 rst_n=0 SHALL force IDLE; br_ack, stall_id, pc_redirect, flush_if = 0; br_target, br_cnt, taken_cnt = 0.
REQ-029 Reset in HOLD or REDIRECT SHALL abort the branch with no redirect after release.

Configuration
REQ-030 With macro BRANCH_STATS_EN defined, br_cnt SHALL increment on each resolve of a non-NONE type and taken_cnt on each taken resolve, both saturating at 2^CNT_W-1.
REQ-031 Without BRANCH_STATS_EN, br_cnt and taken_cnt SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-032 br_type encodings and FSM state encodings SHALL live in shared package mips_pkg.
REQ-033 Condition evaluation SHALL be a combinational sub-module br_cond (br_type + flags -> taken).

Verification
REQ-034 BEQ, cmp_eq=1, pc_plus4=0x00400004, imm_ext=0x00000003 -> ack cycle N; pc_redirect=flush_if=1, br_target=0x00400010 in cycle N+1.
REQ-035 BNE, cmp_eq=1 -> ack, no redirect, taken_cnt unchanged, br_cnt+1 (stats on).
REQ-036 BLTZ, opnd_wait=1 for 3 cycles, then cmp_ltz=1 -> stall_id=1 for 3 cycles, ack in 4th, redirect in 5th.
REQ-037 imm_ext=0xFFFFFFFF, pc_plus4=0x00000000 -> br_target=0xFFFFFFFC (wrap).
REQ-038 rst_n low in REDIRECT cycle -> all outputs 0 immediately, no redirect after release.
REQ-039 Stats on, CNT_W=4, 17 taken branches -> br_cnt=taken_cnt=0xF saturated; stats off -> both 0.
